// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_pkg
// Brief   : FSM state encoding and JK next-state function shared by the
//           JK target counter RTL.
// Revision: 1.0 - initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } jk_state_e;

    // Classic JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic n;
        case ({j, k})
            2'b00:   n = q;
            2'b01:   n = 1'b0;
            2'b10:   n = 1'b1;
            default: n = ~q;
        endcase
        return n;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_stage.sv
`default_nettype none
// ============================================================================
// Module  : jk_stage
// Brief   : Single rising-edge JK flip-flop with asynchronous active-high
//           reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
module jk_stage
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= jk_next(q, j, k);
        end
    end

endmodule : jk_stage
`default_nettype wire

// File: rtl/jk_target_counter.sv
`default_nettype none
// ============================================================================
// Module  : jk_target_counter
// Brief   : Steps a WIDTH-bit register of JK stages toward a requested target,
//           one count per clock, with valid/ready target intake and done pulse.
//           Define JK_EXCITE_OBS_EN to expose the live J/K vectors (obs_j/k).
// Revision: 1.0 - initial release
// ============================================================================
module jk_target_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_target,
    output logic             in_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             dir_up
`ifdef JK_EXCITE_OBS_EN
    ,
    output logic [WIDTH-1:0] obs_j,
    output logic [WIDTH-1:0] obs_k
`endif
);

    jk_state_e        state;
    jk_state_e        state_nxt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] toggle;
    logic             accept;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign accept   = in_valid & in_ready;
    assign q_step   = dir_up ? (q + 1'b1) : (q - 1'b1);

    always_ff @(posedge C or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (in_target == q) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (q_step == target) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Direction only changes on a real run; a zero-distance target keeps the last one.
    always_ff @(posedge C or posedge RESET) begin
        if (RESET) begin
            target <= '0;
            dir_up <= 1'b1;
        end else if (accept) begin
            target <= in_target;
            if (in_target != q) begin
                dir_up <= (in_target > q);
            end
        end
    end

    // Binary counter as toggle stages: bit i flips when all lower bits are
    // 1 (counting up) or all 0 (counting down).
    always_comb begin : excite
        logic up_run;
        logic dn_run;
        toggle = '0;
        up_run = 1'b1;
        dn_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = busy & (dir_up ? up_run : dn_run);
            up_run    = up_run & q[i];
            dn_run    = dn_run & ~q[i];
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            jk_stage u_stage (
                .clk (C),
                .rst (RESET),
                .j   (toggle[gi]),
                .k   (toggle[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

`ifdef JK_EXCITE_OBS_EN
    assign obs_j = toggle;
    assign obs_k = toggle;
`endif

endmodule : jk_target_counter
`default_nettype wire

// File: tb/tb_jk_target_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_target_counter
// Brief   : Self-checking bench for jk_target_counter against a behavioural
//           distance-countdown model, with directed and random targets.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jk_target_counter;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             C = 1'b0;
    logic             RESET = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_target = '0;
    logic             in_ready;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             dir_up;
`ifdef JK_EXCITE_OBS_EN
    logic [WIDTH-1:0] obs_j;
    logic [WIDTH-1:0] obs_k;
`endif

    jk_target_counter #(.WIDTH(WIDTH)) dut (
        .C         (C),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_target (in_target),
        .in_ready  (in_ready),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .dir_up    (dir_up)
`ifdef JK_EXCITE_OBS_EN
        ,
        .obs_j     (obs_j),
        .obs_k     (obs_k)
`endif
    );

    always #5 C = ~C;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a run is "distance left to travel" plus a pending done flag.
    int m_q    = 0;
    int m_left = 0;
    bit m_done = 0;
    bit m_dir  = 1;
    int m_acc  = 0;

    always @(posedge C or posedge RESET) begin
        if (RESET) begin
            m_q = 0; m_left = 0; m_done = 0; m_dir = 1;
        end else if (m_left > 0) begin
            m_q    = m_dir ? m_q + 1 : m_q - 1;
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (in_valid) begin
            m_acc++;
            if (int'(in_target) == m_q) begin
                m_done = 1;
            end else begin
                m_dir  = (int'(in_target) > m_q);
                m_left = m_dir ? int'(in_target) - m_q : m_q - int'(in_target);
            end
        end
    end

    always @(negedge C) begin
        chk("q",        32'(q),        32'(m_q));
        chk("busy",     32'(busy),     32'(m_left > 0));
        chk("done",     32'(done),     32'(m_done));
        chk("in_ready", 32'(in_ready), 32'(m_left == 0 && !m_done));
        chk("dir_up",   32'(dir_up),   32'(m_dir));
        if (m_q < 0 || m_q > MAXV) begin
            n_bad++;
            $display("FAIL model_range: got %0d expected 0..%0d", m_q, MAXV);
        end
    end

    task automatic send(input int t);
        int a0;
        @(negedge C); #1;
        in_valid  = 1'b1;
        in_target = WIDTH'(t);
        a0 = m_acc;
        for (int i = 0; i < 40 && m_acc == a0; i++) begin
            @(posedge C); #1;
        end
        if (m_acc == a0) chk("accept_timeout", 32'(m_acc), 32'(a0 + 1));
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40 && !in_ready; i++) begin
            @(posedge C); #1;
        end
        if (i == 40) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        // reset state
        #13;
        chk("rst_q",      32'(q),        32'd0);
        chk("rst_ready",  32'(in_ready), 32'd1);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_dir",    32'(dir_up),   32'd1);
        @(negedge C); #1 RESET = 1'b0;

        // 0 -> 3
        send(3);
        chk("up_accept_q", 32'(q), 32'd0);
        chk("up_busy",     32'(busy), 32'd1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge C); #1;
            chk("up_q", 32'(q), 32'(e));
        end
        chk("up_done", 32'(done), 32'd1);
        chk("up_ready_low", 32'(in_ready), 32'd0);
        @(posedge C); #1;
        chk("up_done_clr", 32'(done), 32'd0);
        chk("up_ready", 32'(in_ready), 32'd1);

        // 3 -> 5, then 5 -> 2 downward
        send(5); wait_idle();
        send(2);
        chk("dn_dir", 32'(dir_up), 32'd0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge C); #1;
            chk("dn_q", 32'(q), 32'(5 - e));
        end
        chk("dn_done", 32'(done), 32'd1);
        wait_idle();

        // same target: done with no counting
        send(7); wait_idle();
        send(7);
        chk("eq_done", 32'(done), 32'd1);
        chk("eq_busy", 32'(busy), 32'd0);
        chk("eq_q",    32'(q),    32'd7);
        wait_idle();

        // valid held through a run with a changed target: ignored until idle
        send(12);
        in_valid = 1'b1; in_target = 4'd1;
        n = m_acc;
        for (int i = 0; i < 40 && m_acc == n; i++) begin
            @(posedge C); #1;
        end
        in_valid = 1'b0;
        chk("hold_acc", 32'(m_acc), 32'(n + 1));
        wait_idle();
        chk("hold_q", 32'(q), 32'd1);

        // reset mid-run at q=6 heading to 15
        send(15);
        for (int i = 0; i < 20 && q != 4'd6; i++) begin
            @(posedge C); #1;
        end
        chk("pre_rst_q", 32'(q), 32'd6);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_q",     32'(q),        32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_done",  32'(done),     32'd0);
        @(negedge C); #1 RESET = 1'b0;

        // full span 0 -> 15 then 15 -> 0
        send(15);
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge C); #1;
            n++;
        end
        chk("span_up_edges", 32'(n), 32'd15);
        chk("span_up_q", 32'(q), 32'd15);
        wait_idle();
        send(0); wait_idle();
        chk("span_dn_q", 32'(q), 32'd0);

        // random traffic, including occasional async reset
        for (int c = 0; c < 1500; c++) begin
            @(negedge C); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_target = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 RESET = 1'b1;
                #1 RESET = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge C);
        @(negedge C); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_jk_target_counter
`default_nettype wire
